// File: rtl/read_file_pkg.sv
// Shared constants and types for the read_file register file.
package read_file_pkg;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    typedef logic [WIDTH-1:0]  word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage : read_file_pkg

// File: rtl/read_file_rf_read_mux.sv
// DEPTH:1 read multiplexer selecting one WIDTH-bit word from the storage array.
module rf_read_mux
    import read_file_pkg::*;
#(
    parameter int WIDTH  = read_file_pkg::WIDTH,
    parameter int ADDR_W = read_file_pkg::ADDR_W,
    parameter int DEPTH  = read_file_pkg::DEPTH
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] data_i,
    input  logic [ADDR_W-1:0]           sel_i,
    output logic [WIDTH-1:0]            dout_o
);

    logic [WIDTH-1:0] dout_s;

    // Combinational word select; every address is in range since DEPTH == 2**ADDR_W.
    always_comb begin
        dout_s = data_i[sel_i];
    end

    assign dout_o = dout_s;

endmodule : rf_read_mux

// File: rtl/read_file.sv
// Two-read, one-write register file. Entries reset to their own index and
// are read combinationally; writes land on the rising clock edge.
module read_file
    import read_file_pkg::*;
#(
    parameter int WIDTH  = read_file_pkg::WIDTH,
    parameter int ADDR_W = read_file_pkg::ADDR_W,
    parameter int DEPTH  = read_file_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] inp1,
    input  logic [ADDR_W-1:0] inp2,
    output logic [WIDTH-1:0]  Zout1,
    output logic [WIDTH-1:0]  Zout2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [DEPTH-1:0][WIDTH-1:0] mem_d;
    logic [WIDTH-1:0]            rd1_s;
    logic [WIDTH-1:0]            rd2_s;

    // Next-state of the array: only the addressed word changes when writing.
    always_comb begin
        mem_d = mem_q;
        if (we == 1'b1) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage: async reset loads the index pattern and overrides any write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= WIDTH'(i);
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    rf_read_mux #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_rd1_mux (
        .data_i (mem_q),
        .sel_i  (inp1),
        .dout_o (rd1_s)
    );

    rf_read_mux #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_rd2_mux (
        .data_i (mem_q),
        .sel_i  (inp2),
        .dout_o (rd2_s)
    );

    // Read data goes straight out: zero-latency reads, no write bypass.
    assign Zout1 = rd1_s;
    assign Zout2 = rd2_s;

endmodule : read_file

// File: tb/tb_read_file.sv
// Directed self-checking bench for the read_file register file.
module tb_read_file;
    import read_file_pkg::*;

    logic  clk;
    logic  rst_n;
    addr_t inp1;
    addr_t inp2;
    word_t Zout1;
    word_t Zout2;
    logic  we;
    addr_t waddr;
    word_t wdata;

    int n_checks;
    int n_fail;

    read_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .inp1  (inp1),
        .inp2  (inp2),
        .Zout1 (Zout1),
        .Zout2 (Zout2),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input word_t obs, input word_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 32'h%08h, expected 32'h%08h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        we       = 1'b0;
        waddr    = 5'd0;
        wdata    = 32'h0000_0000;
        inp1     = 5'd15;
        inp2     = 5'd8;

        // Reset pattern, visible while still in reset and after release.
        #12;
        check_eq("rst_hold_z1", Zout1, 32'h0000_000F);
        check_eq("rst_hold_z2", Zout2, 32'h0000_0008);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_z1_e15", Zout1, 32'h0000_000F);
        check_eq("rst_z2_e8",  Zout2, 32'h0000_0008);

        // Sweep: port 1 ascending, port 2 descending.
        for (int i = 0; i < 32; i++) begin
            inp1 = addr_t'(i);
            inp2 = addr_t'(31 - i);
            #1;
            check_eq("sweep_z1", Zout1, word_t'(i));
            check_eq("sweep_z2", Zout2, word_t'(31 - i));
        end

        // Write then read: old value before the edge, new value after.
        @(negedge clk);
        inp1  = 5'd15;
        inp2  = 5'd8;
        we    = 1'b1;
        waddr = 5'd15;
        wdata = 32'hDEAD_BEEF;
        #1;
        check_eq("wr_pre_z1", Zout1, 32'h0000_000F);
        check_eq("wr_pre_z2", Zout2, 32'h0000_0008);
        @(posedge clk);
        #1;
        check_eq("wr_post_z1", Zout1, 32'hDEAD_BEEF);
        check_eq("wr_post_z2", Zout2, 32'h0000_0008);
        we = 1'b0;

        // Write disabled must leave entry 3 alone.
        @(negedge clk);
        we    = 1'b0;
        waddr = 5'd3;
        wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        inp1 = 5'd3;
        #1;
        check_eq("we0_e3", Zout1, 32'h0000_0003);

        // Entry 0 is writable; both ports read the same entry.
        @(negedge clk);
        we    = 1'b1;
        waddr = 5'd0;
        wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        we   = 1'b0;
        inp1 = 5'd0;
        inp2 = 5'd0;
        #1;
        check_eq("dual_z1_e0", Zout1, 32'h1234_5678);
        check_eq("dual_z2_e0", Zout2, 32'h1234_5678);

        // Top entry write; neighbour 30 untouched.
        @(negedge clk);
        we    = 1'b1;
        waddr = 5'd31;
        wdata = 32'h8000_0001;
        @(posedge clk);
        #1;
        we   = 1'b0;
        inp1 = 5'd30;
        inp2 = 5'd31;
        #1;
        check_eq("e30_keep", Zout1, 32'h0000_001E);
        check_eq("e31_wr",   Zout2, 32'h8000_0001);

        // Async reset mid-operation.
        @(negedge clk);
        we    = 1'b1;
        waddr = 5'd20;
        wdata = 32'hA5A5_A5A5;
        inp1  = 5'd20;
        inp2  = 5'd0;
        @(posedge clk);
        #1;
        we = 1'b0;
        check_eq("pre_rst_e20", Zout1, 32'hA5A5_A5A5);
        check_eq("pre_rst_e0",  Zout2, 32'h1234_5678);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_e20", Zout1, 32'h0000_0014);
        check_eq("async_rst_e0",  Zout2, 32'h0000_0000);
        we    = 1'b1;
        waddr = 5'd20;
        wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        check_eq("rst_blocks_wr", Zout1, 32'h0000_0014);

        // First write right after release lands on the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        we    = 1'b1;
        waddr = 5'd20;
        wdata = 32'hCAFE_F00D;
        #1;
        check_eq("rel_pre_wr", Zout1, 32'h0000_0014);
        @(posedge clk);
        #1;
        we = 1'b0;
        check_eq("rel_first_wr", Zout1, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule : tb_read_file
